// File: rtl/kugelblitz_patch_ctrl_if.sv
// AXI-lite slave bundle for the kugelblitz patch controller register file.
interface kugelblitz_patch_ctrl_if #(
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned AXIL_ADDR_WIDTH = 32,
    parameter int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
);
    logic [AXIL_ADDR_WIDTH-1:0] awaddr;
    logic [2:0]                 awprot;
    logic                       awvalid;
    logic                       awready;
    logic [AXIL_DATA_WIDTH-1:0] wdata;
    logic [AXIL_STRB_WIDTH-1:0] wstrb;
    logic                       wvalid;
    logic                       wready;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;
    logic [AXIL_ADDR_WIDTH-1:0] araddr;
    logic [2:0]                 arprot;
    logic                       arvalid;
    logic                       arready;
    logic [AXIL_DATA_WIDTH-1:0] rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/kugelblitz_patch_ctrl.sv
// Frame-safe patch register block: shadow regs are committed to the kg_* outputs only between frames.
// Define KG_PATCH_FRAME_COUNT_EN to build the FRAME_COUNT register at 0x10.
module kugelblitz_patch_ctrl #(
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned AXIL_ADDR_WIDTH = 32,
    parameter int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    kugelblitz_patch_ctrl_if.slave s_axil,
    input  logic                   mon_axis_tvalid,
    input  logic                   mon_axis_tready,
    input  logic                   mon_axis_tlast,
    output logic [5:0]             kg_address,
    output logic [7:0]             kg_data,
    output logic                   kg_address_valid,
    output logic                   kg_data_valid
);
    localparam logic [5:0] RegCtrl      = 6'h00;
    localparam logic [5:0] RegPatchAddr = 6'h01;
    localparam logic [5:0] RegPatchData = 6'h02;
    localparam logic [5:0] RegStatus    = 6'h03;
`ifdef KG_PATCH_FRAME_COUNT_EN
    localparam logic [5:0] RegFrameCnt  = 6'h04;
`endif

    logic [AXIL_ADDR_WIDTH-1:0] awaddr, araddr;
    logic [AXIL_DATA_WIDTH-1:0] wdata, rd_val;
    logic [AXIL_STRB_WIDTH-1:0] wstrb;

    logic awready_q, awready_d, bvalid_q, bvalid_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic wr_fire, rd_fire, commit_wr, cnt_clr, beat, apply;

    logic       en_sh_q, en_sh_d, act_en_q, act_en_d;
    logic [5:0] addr_sh_q, addr_sh_d, act_addr_q, act_addr_d;
    logic [7:0] data_sh_q, data_sh_d, act_data_q, act_data_d;
    logic       commit_pend_q, commit_pend_d, in_frame_q, in_frame_d;

    assign awaddr = s_axil.awaddr;
    assign araddr = s_axil.araddr;
    assign wdata  = s_axil.wdata;
    assign wstrb  = s_axil.wstrb;

    logic unused_bits;
    assign unused_bits = ^{awaddr, araddr, wdata, wstrb, s_axil.awprot, s_axil.arprot};

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = awready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = 2'b00;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = 2'b00;

    assign kg_address       = act_addr_q;
    assign kg_data          = act_data_q;
    assign kg_address_valid = act_en_q;
    assign kg_data_valid    = act_en_q;

    // Ready is a one-cycle registered pulse; the handshake completes in the cycle it is high.
    assign wr_fire = awready_q & s_axil.awvalid & s_axil.wvalid;
    assign rd_fire = arready_q & s_axil.arvalid;
    assign beat    = mon_axis_tvalid & mon_axis_tready;
    assign apply   = commit_pend_q & ~in_frame_q & ~mon_axis_tvalid;

    always_comb begin
        awready_d = s_axil.awvalid & s_axil.wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = wr_fire | (bvalid_q & ~s_axil.bready);
        arready_d = s_axil.arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rd_fire | (rvalid_q & ~s_axil.rready);
        rdata_d   = rd_fire ? rd_val : rdata_q;
    end

    always_comb begin
        en_sh_d   = en_sh_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        commit_wr = 1'b0;
        cnt_clr   = 1'b0;
        if (wr_fire && wstrb[0]) begin
            case (awaddr[7:2])
                RegCtrl: begin
                    en_sh_d   = wdata[0];
                    commit_wr = wdata[1];
                    cnt_clr   = wdata[2];
                end
                RegPatchAddr: addr_sh_d = wdata[5:0];
                RegPatchData: data_sh_d = wdata[7:0];
                default: ;
            endcase
        end
    end

    // Apply copies the next-state shadow so a same-cycle shadow write is not lost.
    always_comb begin
        act_en_d      = apply ? en_sh_d : act_en_q;
        act_addr_d    = apply ? addr_sh_d : act_addr_q;
        act_data_d    = apply ? data_sh_d : act_data_q;
        commit_pend_d = (commit_pend_q & ~apply) | commit_wr;
        in_frame_d    = beat ? ~mon_axis_tlast : in_frame_q;
    end

`ifdef KG_PATCH_FRAME_COUNT_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (cnt_clr) begin
            frame_cnt_d = '0;
        end else if (beat && mon_axis_tlast && act_en_q) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
`endif

    always_comb begin
        rd_val = '0;
        case (araddr[7:2])
            RegCtrl:      rd_val[0]   = en_sh_q;
            RegPatchAddr: rd_val[5:0] = addr_sh_q;
            RegPatchData: rd_val[7:0] = data_sh_q;
            RegStatus:    rd_val[1:0] = {in_frame_q, commit_pend_q};
`ifdef KG_PATCH_FRAME_COUNT_EN
            RegFrameCnt:  rd_val      = frame_cnt_q;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q     <= 1'b0;
            bvalid_q      <= 1'b0;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            en_sh_q       <= 1'b0;
            addr_sh_q     <= '0;
            data_sh_q     <= '0;
            act_en_q      <= 1'b0;
            act_addr_q    <= '0;
            act_data_q    <= '0;
            commit_pend_q <= 1'b0;
            in_frame_q    <= 1'b0;
        end else begin
            awready_q     <= awready_d;
            bvalid_q      <= bvalid_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            en_sh_q       <= en_sh_d;
            addr_sh_q     <= addr_sh_d;
            data_sh_q     <= data_sh_d;
            act_en_q      <= act_en_d;
            act_addr_q    <= act_addr_d;
            act_data_q    <= act_data_d;
            commit_pend_q <= commit_pend_d;
            in_frame_q    <= in_frame_d;
        end
    end
endmodule

// File: tb/tb_kugelblitz_patch_ctrl.sv
// Scoreboard bench for kugelblitz_patch_ctrl: read data and kg_* output changes are checked
// by monitors against expected values queued by the directed stimulus.
module tb_kugelblitz_patch_ctrl;
    localparam logic [31:0] ACtrl = 32'h00;
    localparam logic [31:0] AAddr = 32'h04;
    localparam logic [31:0] AData = 32'h08;
    localparam logic [31:0] AStat = 32'h0C;
    localparam logic [31:0] ACnt  = 32'h10;
    localparam int Tmo = 50;
`ifdef KG_PATCH_FRAME_COUNT_EN
    localparam logic [31:0] ExpCnt3 = 32'd3;
    localparam logic [31:0] ExpCnt1 = 32'd1;
`else
    localparam logic [31:0] ExpCnt3 = 32'd0;
    localparam logic [31:0] ExpCnt1 = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic mon_tvalid, mon_tready, mon_tlast;
    logic [5:0] kg_address;
    logic [7:0] kg_data;
    logic kg_address_valid, kg_data_valid;

    always #5 clk = ~clk;

    kugelblitz_patch_ctrl_if #(.AXIL_DATA_WIDTH(32), .AXIL_ADDR_WIDTH(32)) axil ();

    kugelblitz_patch_ctrl #(.AXIL_DATA_WIDTH(32), .AXIL_ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axil           (axil),
        .mon_axis_tvalid  (mon_tvalid),
        .mon_axis_tready  (mon_tready),
        .mon_axis_tlast   (mon_tlast),
        .kg_address       (kg_address),
        .kg_data          (kg_data),
        .kg_address_valid (kg_address_valid),
        .kg_data_valid    (kg_data_valid)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [15:0] kg_q[$];
    logic [15:0] kg_prev = '0;
    logic [15:0] kg_cur;

    assign kg_cur = {kg_address_valid, kg_data_valid, kg_address, kg_data};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string what);
        checks++;
        errors++;
        $display("FAIL timeout_%s: no handshake within %0d cycles", what, Tmo);
    endtask

    // Monitors: sample away from the active edge.
    always @(negedge clk) begin
        rd_exp_t e;
        if (rst_n && axil.rvalid && axil.rready) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_unexpected: got 0x%0h with no read outstanding", axil.rdata);
            end else begin
                e = rd_q.pop_front();
                chk($sformatf("rdata@0x%0h", e.addr), axil.rdata, e.exp);
                chk("rresp", {30'd0, axil.rresp}, 32'd0);
            end
        end
        if (rst_n && axil.bvalid && axil.bready) begin
            chk("bresp", {30'd0, axil.bresp}, 32'd0);
        end
        if (kg_cur !== kg_prev) begin
            if (kg_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL kg_unexpected_change: got 0x%0h, expected 0x%0h", kg_cur, kg_prev);
            end else begin
                chk("kg_change", {16'd0, kg_cur}, {16'd0, kg_q.pop_front()});
            end
            kg_prev <= kg_cur;
        end
    end

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_aw();
        bit seen = 1'b0;
        for (int i = 0; i < Tmo; i++) begin
            @(negedge clk);
            if (axil.awready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_timeout("awready");
    endtask

    task automatic aw_issue(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        axil.awaddr  = addr;
        axil.wdata   = data;
        axil.wstrb   = strb;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        wait_aw();
        resync();
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
    endtask

    task automatic b_wait();
        bit seen = 1'b0;
        for (int i = 0; i < Tmo; i++) begin
            @(negedge clk);
            if (axil.bvalid && axil.bready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_timeout("bvalid");
        resync();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb = 4'hF);
        aw_issue(addr, data, strb);
        b_wait();
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        bit seen = 1'b0;
        rd_q.push_back('{addr: addr, exp: exp});
        axil.araddr  = addr;
        axil.arvalid = 1'b1;
        for (int i = 0; i < Tmo; i++) begin
            @(negedge clk);
            if (axil.arready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_timeout("arready");
        resync();
        axil.arvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < Tmo; i++) begin
            @(negedge clk);
            if (axil.rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_timeout("rvalid");
        resync();
    endtask

    task automatic beat(input logic last);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = last;
        resync();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
        axil.wdata  = '0; axil.wstrb  = '0; axil.wvalid  = 1'b0;
        axil.bready = 1'b1;
        axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0;
        axil.rready = 1'b1;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_kg", {16'd0, kg_cur}, 32'd0);
        chk("reset_awready", {31'd0, axil.awready}, 32'd0);
        chk("reset_wready", {31'd0, axil.wready}, 32'd0);
        chk("reset_bvalid", {31'd0, axil.bvalid}, 32'd0);
        chk("reset_arready", {31'd0, axil.arready}, 32'd0);
        chk("reset_rvalid", {31'd0, axil.rvalid}, 32'd0);
        chk("reset_rdata", axil.rdata, 32'd0);
        rst_n = 1'b1;
        resync();
        rd(ACtrl, 32'd0);
        rd(AStat, 32'd0);

        // Idle commit: ADDR=5, DATA=0xAB, CTRL=0x3
        wr(AAddr, 32'h5);
        wr(AData, 32'hAB);
        kg_q.push_back(16'hC5AB);
        wr(ACtrl, 32'h3);
        @(negedge clk);
        chk("kg_after_idle_commit", {16'd0, kg_cur}, 32'h0000_C5AB);
        resync();
        rd(AStat, 32'd0);
        rd(ACtrl, 32'd1);

        // Strobes, unmapped/read-only addresses, ignored addr[1:0]
        wr(AAddr, 32'h3F, 4'h0);
        rd(AAddr, 32'h5);
        wr(AData, 32'hFFFF_FF12, 4'h1);
        rd(AData, 32'h12);
        wr(AData, 32'h34, 4'hE);
        rd(AData, 32'h12);
        wr(32'h40, 32'hFFFF_FFFF);
        rd(32'h40, 32'd0);
        wr(AStat, 32'hFFFF_FFFF);
        rd(AStat, 32'd0);
        rd(32'h0B, 32'h12);
        rd(ACnt, 32'd0);

        // Commit held off by an open frame
        beat(1'b0);
        wr(AAddr, 32'h10);
        kg_q.push_back(16'h1012);
        wr(ACtrl, 32'h2);
        repeat (3) @(negedge clk);
        chk("kg_hold_in_frame", {16'd0, kg_cur}, 32'h0000_C5AB);
        resync();
        rd(AStat, 32'h3);
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
        @(negedge clk);
        chk("kg_hold_tlast_beat", {16'd0, kg_cur}, 32'h0000_C5AB);
        resync();
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        @(negedge clk);
        chk("kg_hold_apply_cycle", {16'd0, kg_cur}, 32'h0000_C5AB);
        resync();
        @(negedge clk);
        chk("kg_after_frame", {16'd0, kg_cur}, 32'h0000_1012);
        resync();
        kg_q.push_back(16'hD012);
        wr(ACtrl, 32'h3);
        rd(AStat, 32'd0);

        // Commit held off by a stalled tvalid
        mon_tvalid = 1'b1;
        wr(AData, 32'h77);
        kg_q.push_back(16'hD077);
        wr(ACtrl, 32'h3);
        repeat (4) @(negedge clk);
        chk("kg_hold_tvalid", {16'd0, kg_cur}, 32'h0000_D012);
        resync();
        rd(AStat, 32'h1);
        mon_tvalid = 1'b0;
        resync();
        @(negedge clk);
        chk("kg_after_tvalid_drop", {16'd0, kg_cur}, 32'h0000_D077);
        resync();

        // Shadow write while pending: newest shadow is committed
        mon_tvalid = 1'b1;
        kg_q.push_back(16'hD099);
        wr(ACtrl, 32'h3);
        wr(AData, 32'h99);
        rd(AStat, 32'h1);
        @(negedge clk);
        chk("kg_hold_pending", {16'd0, kg_cur}, 32'h0000_D077);
        resync();
        mon_tvalid = 1'b0;
        repeat (3) resync();
        rd(AStat, 32'd0);

        // Back-pressured write response blocks a second write
        axil.bready = 1'b0;
        aw_issue(AAddr, 32'h2A, 4'hF);
        @(negedge clk);
        chk("bvalid_held_first", {31'd0, axil.bvalid}, 32'd1);
        axil.awaddr = AData; axil.wdata = 32'h55; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("awready_blocked", {31'd0, axil.awready}, 32'd0);
            chk("bvalid_held", {31'd0, axil.bvalid}, 32'd1);
        end
        resync();
        axil.bready = 1'b1;
        b_wait();
        aw_issue(AData, 32'h55, 4'hF);
        b_wait();
        rd(AAddr, 32'h2A);
        rd(AData, 32'h55);

        // Simultaneous read and write of one register returns the pre-write value
        fork
            wr(AData, 32'hC3);
            rd(AData, 32'h55);
        join
        rd(AData, 32'hC3);

        // COMMIT write landing in the apply cycle keeps COMMIT_PENDING
        mon_tvalid = 1'b1;
        kg_q.push_back(16'hEAC3);
        wr(ACtrl, 32'h3);
        fork
            wr(ACtrl, 32'h3);
            begin
                wait_aw();
                mon_tvalid = 1'b0;
                resync();
                mon_tvalid = 1'b1;
            end
        join
        rd(AStat, 32'h1);
        @(negedge clk);
        chk("kg_after_coincident_commit", {16'd0, kg_cur}, 32'h0000_EAC3);
        resync();
        mon_tvalid = 1'b0;
        repeat (3) resync();
        rd(AStat, 32'd0);

        // Asynchronous reset in the middle of pending transactions
        axil.awaddr = AData; axil.wdata = 32'hEE; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        axil.araddr = ACtrl; axil.arvalid = 1'b1;
        @(posedge clk);
        #3;
        kg_q.push_back(16'h0000);
        rst_n = 1'b0;
        #1;
        chk("async_reset_kg", {16'd0, kg_cur}, 32'd0);
        chk("async_reset_awready", {31'd0, axil.awready}, 32'd0);
        chk("async_reset_arready", {31'd0, axil.arready}, 32'd0);
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resync();
        rd(AData, 32'd0);
        rd(ACtrl, 32'd0);
        rd(AStat, 32'd0);

        // Frame counter (reads 0 when not built)
        kg_q.push_back(16'hC000);
        wr(ACtrl, 32'h3);
        repeat (3) begin
            beat(1'b0);
            beat(1'b1);
        end
        rd(ACnt, ExpCnt3);
        beat(1'b0);
        fork
            wr(ACtrl, 32'h5);
            begin
                wait_aw();
                mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
                resync();
                mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
            end
        join
        rd(ACnt, 32'd0);
        beat(1'b0);
        beat(1'b1);
        rd(ACnt, ExpCnt1);
        rd(AStat, 32'd0);
        rd(ACtrl, 32'd1);

        repeat (2) resync();
        chk("rd_queue_drained", rd_q.size(), 32'd0);
        chk("kg_queue_drained", kg_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
